// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
//   Definitions shared by the snake game core, the tick generator and the
//   direction controller: direction codes, the opposite-direction rule,
//   game-phase encoding and the button index map used by the controller.
// -----------------------------------------------------------------------------
package snake_pkg;

  // Direction codes as seen on the core's 2-bit dir input.
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  // Positions of the five buttons in the controller's internal vectors.
  localparam int BTN_U  = 0;
  localparam int BTN_R  = 1;
  localparam int BTN_D  = 2;
  localparam int BTN_L  = 3;
  localparam int BTN_C  = 4;
  localparam int NUM_BTN = 5;

  // Game phase.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } game_state_t;

  // The encoding places opposite directions two apart, so flipping the MSB
  // turns a direction into its reverse.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

  // Resolve simultaneous direction press events: U > R > D > L.
  // ev bit order follows the BTN_* indices {L, D, R, U}.
  function automatic logic [1:0] prio_dir(input logic [3:0] ev);
    logic [1:0] d;
    if (ev[BTN_U])      d = DIR_UP;
    else if (ev[BTN_R]) d = DIR_RIGHT;
    else if (ev[BTN_D]) d = DIR_DOWN;
    else                d = DIR_LEFT;
    return d;
  endfunction

endpackage : snake_pkg

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions one raw push-button: two-flop synchroniser, stability counter,
//   debounced level and a one-cycle press pulse on its 0->1 transition.
//
//   Ports
//     CLK_100MHz : system clock
//     Reset      : synchronous, active-high
//     btn_raw    : raw asynchronous button, active-high
//     press      : one-cycle pulse when the debounced level rises
//
//   The debounced level changes only after the synchronised input has
//   disagreed with it for DEBOUNCE_CYCLES consecutive cycles. 2**CNT_W must
//   exceed DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic CLK_100MHz,
  input  logic Reset,
  input  logic btn_raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             stable_dly_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // NOTE: every variable assigned in an always_comb gets a default at the top
  // of the block so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        // Held long enough: accept the new level. The counter clears here
        // rather than wrapping.
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Rising edge of the debounced level, taken one cycle after the flip.
    press_d = stable_q & ~stable_dly_q;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others regardless of statement order.
  // NOTE: reset is synchronous here; it is only seen on a clock edge.
  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= btn_raw;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  assign press = press_q;

endmodule : btn_debounce

// File: rtl/snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl
//   Input-conditioning stage in front of the snake game core. Debounces the
//   five buttons, buffers one pending direction request between game ticks,
//   drops 180-degree reversals, and produces the core's dir and Go signals.
//   A small IDLE/RUN/OVER machine follows the game phase from gameOver.
//
//   Ports
//     CLK_100MHz           : system clock
//     Reset                : synchronous, active-high
//     btnU/btnR/btnD/btnL  : raw direction buttons, active-high
//     btnC                 : raw start button, active-high
//     tick                 : one-cycle pulse, one snake move
//     gameOver             : collision flag from the game core
//     dir                  : committed direction (00 U, 01 R, 10 D, 11 L)
//     Go                   : one-cycle start pulse on IDLE -> RUN
// -----------------------------------------------------------------------------
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic       CLK_100MHz,
  input  logic       Reset,
  input  logic       btnU,
  input  logic       btnR,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnC,
  input  logic       tick,
  input  logic       gameOver,
  output logic [1:0] dir,
  output logic       Go
);

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] press;

  assign btn_raw[BTN_U] = btnU;
  assign btn_raw[BTN_R] = btnR;
  assign btn_raw[BTN_D] = btnD;
  assign btn_raw[BTN_L] = btnL;
  assign btn_raw[BTN_C] = btnC;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .CLK_100MHz (CLK_100MHz),
      .Reset      (Reset),
      .btn_raw    (btn_raw[i]),
      .press      (press[i])
    );
  end

  logic [3:0] dir_ev;
  logic       any_dir_ev;
  logic [1:0] req_dir;

  assign dir_ev     = press[BTN_L:BTN_U];
  assign any_dir_ev = |dir_ev;
  assign req_dir    = prio_dir(dir_ev);

  // ---------------------------------------------------------------------------
  // Game phase, pending buffer and outputs
  // ---------------------------------------------------------------------------
  game_state_t state_q, state_d;
  logic [1:0]  dir_q, dir_d;
  logic        go_q, go_d;
  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_d_q, pend_d_d;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    go_d     = 1'b0;
    pend_v_d = pend_v_q;
    pend_d_d = pend_d_q;

    unique case (state_q)
      ST_IDLE: begin
        // Direction presses and ticks have no effect before the game starts.
        pend_v_d = 1'b0;
        if (press[BTN_C]) begin
          go_d    = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (gameOver) begin
          state_d  = ST_OVER;
          dir_d    = DIR_RIGHT;
          pend_v_d = 1'b0;
        end else begin
          // The tick consumes whatever was pending before this edge.
          if (tick) begin
            if (pend_v_q && (pend_d_q != opposite_dir(dir_q))) begin
              dir_d = pend_d_q;
            end
            pend_v_d = 1'b0;
          end
          // A press in the same cycle survives the tick and waits for the
          // next one; a later press overwrites an earlier one.
          if (any_dir_ev) begin
            pend_d_d = req_dir;
            pend_v_d = 1'b1;
          end
        end
      end

      ST_OVER: begin
        dir_d    = DIR_RIGHT;
        pend_v_d = 1'b0;
        if (!gameOver) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        dir_d    = DIR_RIGHT;
        pend_v_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_100MHz) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_RIGHT;
      go_q     <= 1'b0;
      pend_v_q <= 1'b0;
      pend_d_q <= DIR_UP;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      go_q     <= go_d;
      pend_v_q <= pend_v_d;
      pend_d_q <= pend_d_d;
    end
  end

  assign dir = dir_q;
  assign Go  = go_q;

endmodule : snake_dir_ctrl

// File: tb/tb_snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_dir_ctrl
//   Directed bench for snake_dir_ctrl with DEBOUNCE_CYCLES = 4. Inputs change
//   and outputs are sampled on the falling clock edge. A raw button edge set
//   at a falling edge produces a press event visible after the 7th rising
//   edge, which the top acts on at the 8th.
// -----------------------------------------------------------------------------
module tb_snake_dir_ctrl;
  import snake_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] btn = '0;
  logic       tick = 1'b0;
  logic       game_over = 1'b0;
  logic [1:0] dir;
  logic       go;

  int n_checks = 0;
  int n_pass   = 0;

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .CLK_100MHz (clk),
    .Reset      (rst),
    .btnU       (btn[BTN_U]),
    .btnR       (btn[BTN_R]),
    .btnD       (btn[BTN_D]),
    .btnL       (btn[BTN_L]),
    .btnC       (btn[BTN_C]),
    .tick       (tick),
    .gameOver   (game_over),
    .dir        (dir),
    .Go         (go)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Full press/release of one button; the press event has been absorbed by
  // the top after the first 8 cycles, the release has settled after 16.
  task automatic press(input int idx);
    btn[idx] = 1'b1;
    step(8);
    btn[idx] = 1'b0;
    step(8);
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  // Caller raises btnC; released after 'hold' cycles. Counts Go pulses over
  // n cycles and records the cycle of the first one.
  task automatic watch_go(input int hold, input int n, output int cnt, output int at);
    cnt = 0;
    at  = -1;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (i == hold) btn[BTN_C] = 1'b0;
      if (go) begin
        cnt++;
        if (at < 0) at = i;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int gc, ga;

    // 1. Reset and start
    rst = 1'b1;
    step(2);
    check("rst_dir",   32'(dir), 32'(DIR_RIGHT));
    check("rst_go",    32'(go), 0);
    check("rst_pendv", 32'(dut.pend_v_q), 0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    rst = 1'b0;

    btn[BTN_C] = 1'b1;
    watch_go(8, 16, gc, ga);
    check("start_go_cnt", 32'(gc), 1);
    check("start_go_at",  32'(ga), 8);
    check("start_state",  32'(dut.state_q), 32'(ST_RUN));
    btn[BTN_C] = 1'b1;
    watch_go(8, 16, gc, ga);
    check("run_btnc_no_go", 32'(gc), 0);

    // 2. Commit on tick
    check("run_dir0", 32'(dir), 32'(DIR_RIGHT));
    press(BTN_U);
    check("u_pendv", 32'(dut.pend_v_q), 1);
    step(50);
    check("u_no_tick_dir", 32'(dir), 32'(DIR_RIGHT));
    do_tick();
    check("u_tick_dir",   32'(dir), 32'(DIR_UP));
    check("u_tick_pendv", 32'(dut.pend_v_q), 0);
    press(BTN_R);
    do_tick();
    check("r_tick_dir", 32'(dir), 32'(DIR_RIGHT));

    // 3. Reversal, last-wins, bounce
    press(BTN_L);
    do_tick();
    check("rev_dir",   32'(dir), 32'(DIR_RIGHT));
    check("rev_pendv", 32'(dut.pend_v_q), 0);
    press(BTN_U);
    press(BTN_D);
    do_tick();
    check("last_wins_dir", 32'(dir), 32'(DIR_DOWN));
    for (int i = 0; i < 20; i++) begin
      btn[BTN_R] = ~btn[BTN_R];
      step(2);
    end
    btn[BTN_R] = 1'b0;
    step(10);
    check("bounce_pendv", 32'(dut.pend_v_q), 0);
    do_tick();
    check("bounce_dir", 32'(dir), 32'(DIR_DOWN));

    // 4. Simultaneous events
    press(BTN_R);
    do_tick();
    check("sim_pre_dir", 32'(dir), 32'(DIR_RIGHT));
    btn[BTN_U] = 1'b1;
    btn[BTN_L] = 1'b1;
    step(8);
    btn[BTN_U] = 1'b0;
    btn[BTN_L] = 1'b0;
    step(8);
    check("prio_pend_d", 32'(dut.pend_d_q), 32'(DIR_UP));
    do_tick();
    check("prio_dir", 32'(dir), 32'(DIR_UP));

    press(BTN_R);
    do_tick();
    check("coinc_pre_dir", 32'(dir), 32'(DIR_RIGHT));
    press(BTN_D);
    check("coinc_pend_d", 32'(dut.pend_d_q), 32'(DIR_DOWN));
    btn[BTN_L] = 1'b1;
    step(7);
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("coinc_dir",    32'(dir), 32'(DIR_DOWN));
    check("coinc_pendv",  32'(dut.pend_v_q), 1);
    check("coinc_pend_d2", 32'(dut.pend_d_q), 32'(DIR_LEFT));
    btn[BTN_L] = 1'b0;
    step(8);
    do_tick();
    check("coinc_next_dir", 32'(dir), 32'(DIR_LEFT));

    // 5. Game over
    game_over = 1'b1;
    step(1);
    check("go_over_dir",   32'(dir), 32'(DIR_RIGHT));
    check("go_over_state", 32'(dut.state_q), 32'(ST_OVER));
    step(2);
    check("go_hold_state", 32'(dut.state_q), 32'(ST_OVER));
    game_over = 1'b0;
    step(1);
    check("go_idle_state", 32'(dut.state_q), 32'(ST_IDLE));
    press(BTN_U);
    do_tick();
    check("idle_dir",   32'(dir), 32'(DIR_RIGHT));
    check("idle_pendv", 32'(dut.pend_v_q), 0);
    game_over = 1'b1;
    step(2);
    check("idle_gameover_ignored", 32'(dut.state_q), 32'(ST_IDLE));
    game_over = 1'b0;
    btn[BTN_C] = 1'b1;
    watch_go(8, 16, gc, ga);
    check("restart_go_cnt", 32'(gc), 1);
    check("restart_state",  32'(dut.state_q), 32'(ST_RUN));

    // 6. Reset mid-operation
    press(BTN_D);
    do_tick();
    check("mid_pre_dir", 32'(dir), 32'(DIR_DOWN));
    press(BTN_L);
    check("mid_pre_pendv", 32'(dut.pend_v_q), 1);
    rst = 1'b1;
    btn[BTN_C] = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_dir",   32'(dir), 32'(DIR_RIGHT));
    check("mid_rst_pendv", 32'(dut.pend_v_q), 0);
    check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("mid_rst_go",    32'(go), 0);
    watch_go(8, 16, gc, ga);
    check("mid_held_go_cnt", 32'(gc), 1);
    check("mid_held_go_at",  32'(ga), 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_snake_dir_ctrl
